// File: rtl/clock_div_monitor.sv
// clock_div_monitor
// Measures a slow clock (clk_in) from the fast clk domain. Each clk_in rise
// produces one measurement of the previous clk_in period and high time, in
// clk cycles.
//
// Output qualifier: meas_valid is a single-cycle strobe with no back-pressure.
// period and high_time are valid from the cycle meas_valid is high until the
// next strobe. err_pulse is only ever high together with meas_valid.
//
// Lock: LOCK_COUNT consecutive periods within EXP_PERIOD +/- TOL raise locked.
// Any bad period drops locked and restarts the count.
//
// Stall: TIMEOUT cycles without a rise raises a stall strobe and returns to
// ARM.
//
// state_dbg exposes the FSM state with the encoding
// IDLE=0, ARM=1, MEASURE=2, LOCKED=3.
module clock_div_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int EXP_PERIOD  = 100,
    parameter int TOL         = 1,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clk_in,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic             stall,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int LO_INT = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;

    localparam logic [GOOD_W-1:0] GOOD_FULL   = GOOD_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]  PER_LO      = CNT_W'(LO_INT);
    localparam logic [CNT_W-1:0]  PER_HI      = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0]  CNT_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    state_t state;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   sync_out;
    logic                   rise;
    logic                   fall;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  hcnt;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_nxt;

    logic period_ok;
    logic timeout_hit;
    logic meas_set;
    logic err_set;
    logic stall_set;
    logic cnt_clear;

    // Synchronized clk_in and its delayed copy give 1-cycle rise/fall strobes.
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~edge_q;
    assign fall     = ~sync_out & edge_q;

    // The count at a rise is the period just finished.
    assign period_ok   = (cnt >= PER_LO) && (cnt <= PER_HI);
    assign timeout_hit = (cnt == CNT_TIMEOUT);

    // Counters are parked at zero while idle or about to become idle.
    assign cnt_clear = !en || (state == IDLE);

    assign state_dbg = state;

    // Synchronizer chain plus edge-detect flop for the asynchronous clk_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
            edge_q <= sync_out;
        end
    end

    // Cycle counter since the last rise; a stall restarts it from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clear) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_W'(1);
        end else if (stall_set) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // High-time capture.
    // A rise clears it so a cycle with no fall reports 0 at the next rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
        end else if (cnt_clear || rise) begin
            hcnt <= '0;
        end else if (fall) begin
            hcnt <= cnt;
        end
    end

    // FSM state and good-period count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            good  <= '0;
        end else begin
            state <= state_nxt;
            good  <= good_nxt;
        end
    end

    // Next-state logic.
    // A rise takes priority over a timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        meas_set  = 1'b0;
        err_set   = 1'b0;
        stall_set = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            good_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ARM;
                    good_nxt  = '0;
                end
                ARM: begin
                    if (rise) begin
                        state_nxt = MEASURE;
                    end else if (timeout_hit) begin
                        stall_set = 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        meas_set = 1'b1;
                        if (period_ok) begin
                            good_nxt = good + GOOD_W'(1);
                            if (good_nxt == GOOD_FULL) begin
                                state_nxt = LOCKED;
                            end
                        end else begin
                            good_nxt = '0;
                            err_set  = 1'b1;
                        end
                    end else if (timeout_hit) begin
                        stall_set = 1'b1;
                        good_nxt  = '0;
                        state_nxt = ARM;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        meas_set = 1'b1;
                        if (!period_ok) begin
                            good_nxt  = '0;
                            err_set   = 1'b1;
                            state_nxt = MEASURE;
                        end
                    end else if (timeout_hit) begin
                        stall_set = 1'b1;
                        good_nxt  = '0;
                        state_nxt = ARM;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    good_nxt  = '0;
                end
            endcase
        end
    end

    // Registered outputs.
    // The measurement, strobes and locked all update on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            err_pulse  <= 1'b0;
            stall      <= 1'b0;
            locked     <= 1'b0;
        end else begin
            meas_valid <= meas_set;
            err_pulse  <= err_set;
            stall      <= stall_set;
            locked     <= (state_nxt == LOCKED);
            if (meas_set) begin
                period    <= cnt;
                high_time <= hcnt;
            end
        end
    end

    // Sticky error flag.
    // An error event, or a clear arriving while a strobe is still visible,
    // leaves it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else begin
            err_sticky <= err_set | stall_set | err_pulse | stall |
                          (err_sticky & ~clr_err);
        end
    end

endmodule
